// File: rtl/alarm_ring_if.sv
// Bundles the time/alarm inputs and ring outputs that pass between the timekeeping
// top level (master) and alarm_ring_ctrl (slave).
interface alarm_ring_if;
  logic       sec_tick;
  logic [4:0] cur_hours;
  logic [5:0] cur_minutes;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_en;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;

  modport master (
    output sec_tick, cur_hours, cur_minutes, alarm_hours, alarm_minutes,
    output alarm_en, stop, snooze,
    input  buzzer, ringing, snoozed
  );

  modport slave (
    input  sec_tick, cur_hours, cur_minutes, alarm_hours, alarm_minutes,
    input  alarm_en, stop, snooze,
    output buzzer, ringing, snoozed
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring sequencer: time match -> ring with square-wave tone -> snooze/stop/timeout -> lockout.
// Optional feature macro: ALARM_SNOOZE_EN (snooze state, target registers, snooze edge detect).
module alarm_ring_ctrl #(
  parameter int TONE_DIV     = 16,
  parameter int RING_TIMEOUT = 60,
  parameter int SNOOZE_MIN   = 5
) (
  input logic         clk,
  input logic         rst,
  alarm_ring_if.slave bus
);

  // state | meaning
  // IDLE  | armed, waiting for time match;  RINGING | tone active
  // SNOOZE| silent until snooze target;     LOCKOUT | hold off until alarm minute passes
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RINGING = 2'd1;
`ifdef ALARM_SNOOZE_EN
  localparam logic [1:0] ST_SNOOZE  = 2'd2;
`endif
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  localparam int TD_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

  logic [1:0]      state_q, state_d;
  logic [TD_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [7:0]      ring_sec_q, ring_sec_d;
  logic            buzzer_q, buzzer_d;
  logic            ringing_q, ringing_d;
  logic            stop_q;
  logic            stop_edge;
  logic            match;

`ifdef ALARM_SNOOZE_EN
  logic       snoozed_q, snoozed_d;
  logic       snooze_q;
  logic       snooze_edge;
  logic [4:0] tgt_hours_q, tgt_hours_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [6:0] snz_sum;
  logic [4:0] snz_hours;
  logic [5:0] snz_min;
  logic       tgt_hit;

  assign snooze_edge = bus.snooze & ~snooze_q;
  assign snz_sum     = {1'b0, bus.cur_minutes} + 7'(SNOOZE_MIN);
  assign tgt_hit     = (bus.cur_hours == tgt_hours_q) && (bus.cur_minutes == tgt_min_q);

  always_comb begin
    snz_min   = 6'(snz_sum);
    snz_hours = bus.cur_hours;
    if (snz_sum >= 7'd60) begin
      snz_min   = 6'(snz_sum - 7'd60);
      snz_hours = (bus.cur_hours == 5'd23) ? 5'd0 : bus.cur_hours + 5'd1;
    end
  end
`endif

  assign stop_edge = bus.stop & ~stop_q;

  // Out-of-range alarm settings can never equal a legal time, so block them explicitly.
  assign match = bus.alarm_en
              && (bus.alarm_hours <= 5'd23) && (bus.alarm_minutes <= 6'd59)
              && (bus.cur_hours == bus.alarm_hours)
              && (bus.cur_minutes == bus.alarm_minutes);

  always_comb begin
    state_d    = state_q;
    ring_sec_d = ring_sec_q;
    tone_cnt_d = tone_cnt_q;
    buzzer_d   = 1'b0;
`ifdef ALARM_SNOOZE_EN
    tgt_hours_d = tgt_hours_q;
    tgt_min_d   = tgt_min_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (match) state_d = ST_RINGING;
      end
      ST_RINGING: begin
        if (stop_edge) begin
          state_d = ST_LOCKOUT;
        end else if (bus.sec_tick && (ring_sec_q == 8'(RING_TIMEOUT - 1))) begin
          state_d = ST_LOCKOUT;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze_edge) begin
          state_d     = ST_SNOOZE;
          tgt_hours_d = snz_hours;
          tgt_min_d   = snz_min;
`endif
        end else if (bus.sec_tick) begin
          ring_sec_d = ring_sec_q + 8'd1;
        end
      end
`ifdef ALARM_SNOOZE_EN
      ST_SNOOZE: begin
        if (stop_edge)    state_d = ST_LOCKOUT;
        else if (tgt_hit) state_d = ST_RINGING;
      end
`endif
      ST_LOCKOUT: begin
        if (!match) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!bus.alarm_en) state_d = ST_IDLE;

    // Every entry into RINGING restarts the tone phase and the timeout count.
    if (state_d == ST_RINGING) begin
      if (state_q != ST_RINGING) begin
        tone_cnt_d = '0;
        ring_sec_d = 8'd0;
        buzzer_d   = 1'b0;
      end else if (tone_cnt_q == TD_W'(TONE_DIV - 1)) begin
        tone_cnt_d = '0;
        buzzer_d   = ~buzzer_q;
      end else begin
        tone_cnt_d = tone_cnt_q + 1'b1;
        buzzer_d   = buzzer_q;
      end
    end

    ringing_d = (state_d == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
    snoozed_d = (state_d == ST_SNOOZE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tone_cnt_q <= '0;
      ring_sec_q <= 8'd0;
      buzzer_q   <= 1'b0;
      ringing_q  <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tone_cnt_q <= tone_cnt_d;
      ring_sec_q <= ring_sec_d;
      buzzer_q   <= buzzer_d;
      ringing_q  <= ringing_d;
      stop_q     <= bus.stop;
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snoozed_q   <= 1'b0;
      snooze_q    <= 1'b0;
      tgt_hours_q <= 5'd0;
      tgt_min_q   <= 6'd0;
    end else begin
      snoozed_q   <= snoozed_d;
      snooze_q    <= bus.snooze;
      tgt_hours_q <= tgt_hours_d;
      tgt_min_q   <= tgt_min_d;
    end
  end

  assign bus.snoozed = snoozed_q;
`else
  assign bus.snoozed = 1'b0;
`endif

  assign bus.buzzer  = buzzer_q;
  assign bus.ringing = ringing_q;

endmodule

// File: doc/alarm_ring_ctrl.md
Name: alarm_ring_ctrl

Overview:
Downstream consumer of the alarm time set on the chip inputs (hours 5 b, minutes 6 b) and the running time-of-day count.
- Compares current time against the alarm time.
- Sequences the ring / snooze / lockout behaviour.
- Drives a square-wave buzzer output and status flags to the top-level output pins.

Parameters:
TONE_DIV, 16, buzzer half-period in clk cycles (>=2)
RING_TIMEOUT, 60, seconds of continuous ringing before auto-stop (1..255)
SNOOZE_MIN, 5, snooze interval in minutes (1..59)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
sec_tick  in  1  one-clk pulse per second from timekeeping stage
cur_hours  in  5  current hour, 0..23
cur_minutes  in  6  current minute, 0..59
alarm_hours  in  5  alarm hour, 0..23
alarm_minutes  in  6  alarm minute, 0..59
alarm_en  in  1  alarm armed (level)
stop  in  1  stop request, synchronous to clk, acts on rising edge
snooze  in  1  snooze request, synchronous to clk, acts on rising edge
buzzer  out  1  tone output
ringing  out  1  high while in RINGING
snoozed  out  1  high while in SNOOZE

Behaviour:
- Reset (async, active-high):
  - State IDLE; all outputs 0.
  - Tone counter, ring-second counter, snooze target and edge-detect registers all cleared.
- Edge detect: registered copies of stop/snooze, reset 0. An edge is input=1 with previous=0.
- Match: alarm_en && cur_hours==alarm_hours && cur_minutes==alarm_minutes.
  - Alarm values out of range (hours>23 or minutes>59) never match.
- States: IDLE, RINGING, SNOOZE, LOCKOUT. All outputs are registered.
- IDLE:
  - On match, go to RINGING. ringing=1 on the cycle after match is first seen.
  - stop/snooze edges are ignored.
- RINGING:
  - Entry clears the tone counter and the ring-second counter. buzzer starts at 0 and toggles every TONE_DIV clks.
  - Each sec_tick increments the ring-second counter. When the count reaches RING_TIMEOUT, go to LOCKOUT; ringing=0 on the next cycle.
  - stop edge: go to LOCKOUT.
  - snooze edge: go to SNOOZE and latch the target (see below).
  - stop and snooze edges in the same cycle: stop wins.
- SNOOZE:
  - snoozed=1, buzzer=0.
  - When cur time == target, go to RINGING with counters cleared.
  - stop edge: go to LOCKOUT.
- Snooze target computation:
  - target_min = cur_minutes + SNOOZE_MIN. If >=60, subtract 60 and carry 1 hour.
  - hour 23 + carry wraps to 0.
  - Computed in 7-bit arithmetic, stored as 5/6 bits.
- LOCKOUT:
  - All outputs 0.
  - Prevents retrigger within the same alarm minute.
  - Returns to IDLE on the first cycle match is false.
- Global override: alarm_en=0 in any state forces IDLE on the next clk; all outputs 0.
- No other state changes occur without sec_tick or a time change, except edge-triggered ones.

Optional Feature:
ALARM_SNOOZE_EN
- Defined: SNOOZE state, target registers and snooze edge logic are present, as described above.
- Undefined:
  - snooze input is ignored; snoozed is tied 0.
  - SNOOZE state and target registers are not synthesised.
  - RINGING exits only via stop, timeout or alarm_en=0.

Test Plan:
(bench params TONE_DIV=4, RING_TIMEOUT=3, SNOOZE_MIN=5, ALARM_SNOOZE_EN defined)
1. alarm 07:30, alarm_en=1, cur 07:29 -> 07:30 -> ringing=1 one clk later; buzzer 0 for 4 clks, then toggles every 4 clks.
2. Ringing at 07:30, issue 3 sec_ticks -> ringing=0 after the 3rd.
   - Stays 0 while cur=07:30.
   - cur 07:31 then alarm reset to 07:31 -> rings again (lockout released).
3. alarm 23:58 ringing, snooze pulse -> snoozed=1, buzzer=0.
   - cur 00:02 -> no ring.
   - cur 00:03 -> ringing=1, snoozed=0.
4. stop and snooze rising in the same cycle while ringing -> LOCKOUT; ringing=0, snoozed=0.
5. alarm_hours=24, alarm_minutes=0 with cur 24:00/00:00 -> never rings. Ringing at 06:15, drop alarm_en -> ringing=0, buzzer=0 next clk.
6. rst asserted mid-ring between clk edges -> ringing, buzzer, snoozed 0 immediately. After release with cur still on alarm time -> rings again one clk after first clk edge.
